// File: rtl/cv32e40x_instr_obi_responder.sv
// OBI instruction-fetch responder: legal, aligned fetches go to an in-order memory port; others are answered locally with err.
// Optional random A-channel grant stalls are enabled by defining CV32E40X_OBI_RESP_STALL_EN.
module cv32e40x_instr_obi_responder #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        obi_req_i,
  output logic        obi_gnt_o,
  input  logic [31:0] obi_addr_i,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = (AW == 0) ? 1 : AW;
  localparam int unsigned CW = AW + 1;
  localparam logic [32:0] ADDR_LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] ADDR_HI = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

  function automatic logic [IW-1:0] idx(input logic [CW-1:0] ptr);
    if (AW == 0) return '0;
    return ptr[IW-1:0];
  endfunction

  logic [CW-1:0] outstanding;
  logic [CW-1:0] mem_wait;
  logic [CW-1:0] tag_wr_ptr, tag_rd_ptr;
  logic [CW-1:0] dat_wr_ptr, dat_rd_ptr;
  logic          tag_mem [DEPTH];
  logic [31:0]   dat_mem [DEPTH];

  logic        full, legal, bad, stall, grant;
  logic        tag_empty, dat_empty, tag_head;
  logic        dat_push, emit_err, emit_mem, pop;
  logic [32:0] addr_ext;

  assign addr_ext = {1'b0, obi_addr_i};
  assign legal    = (addr_ext >= ADDR_LO) && (addr_ext < ADDR_HI);
  assign bad      = !legal || (obi_addr_i[1:0] != 2'b00);
  assign full     = (outstanding == CW'(DEPTH));

`ifdef CV32E40X_OBI_RESP_STALL_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1, shifted toward the MSB with feedback into bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  assign mem_req_o  = obi_req_i && !bad && !full && !stall;
  assign mem_addr_o = obi_addr_i;
  assign obi_gnt_o  = obi_req_i && !full && !stall && (bad || mem_gnt_i);
  assign grant      = obi_gnt_o;

  assign tag_empty = (tag_wr_ptr == tag_rd_ptr);
  assign dat_empty = (dat_wr_ptr == dat_rd_ptr);
  assign tag_head  = tag_mem[idx(tag_rd_ptr)];

  // Data with no memory tag waiting for it (e.g. left over from before a reset) is dropped
  assign dat_push = mem_rvalid_i && (mem_wait != '0);
  assign emit_err = !tag_empty && tag_head;
  assign emit_mem = !tag_empty && !tag_head && !dat_empty;
  assign pop      = emit_err || emit_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      mem_wait    <= '0;
      tag_wr_ptr  <= '0;
      tag_rd_ptr  <= '0;
      dat_wr_ptr  <= '0;
      dat_rd_ptr  <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(pop);
      mem_wait    <= mem_wait + CW'(grant && !bad) - CW'(dat_push);
      tag_wr_ptr  <= tag_wr_ptr + CW'(grant);
      tag_rd_ptr  <= tag_rd_ptr + CW'(pop);
      dat_wr_ptr  <= dat_wr_ptr + CW'(dat_push);
      dat_rd_ptr  <= dat_rd_ptr + CW'(emit_mem);
    end
  end

  always_ff @(posedge clk) begin
    if (grant)    tag_mem[idx(tag_wr_ptr)] <= bad;
    if (dat_push) dat_mem[idx(dat_wr_ptr)] <= mem_rdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obi_rvalid_o <= 1'b0;
      obi_rdata_o  <= '0;
      obi_err_o    <= 1'b0;
    end else begin
      obi_rvalid_o <= pop;
      if (emit_err) begin
        obi_err_o   <= 1'b1;
        obi_rdata_o <= '0;
      end else if (emit_mem) begin
        obi_err_o   <= 1'b0;
        obi_rdata_o <= dat_mem[idx(dat_rd_ptr)];
      end
    end
  end

endmodule

// File: doc/cv32e40x_instr_obi_responder.md
Name: cv32e40x_instr_obi_responder

Overview:
- Slave/responder end of the OBI instruction-fetch protocol, used as the fetch target in core-level benches and small subsystems.
- Grants OBI A-channel requests and forwards in-range, word-aligned fetches to an in-order, variable-latency backing memory port.
- Out-of-range or misaligned fetches are answered locally with err=1.
- R-channel responses are returned strictly in request order; the master is always ready for rvalid.

Parameters:
DEPTH, 2, max outstanding OBI transactions (granted, not yet responded); power of 2, >=1
ADDR_BASE, 32'h0000_0000, first legal fetch address
ADDR_SIZE, 32'h0001_0000, legal window size in bytes; legal iff ADDR_BASE <= addr < ADDR_BASE+ADDR_SIZE (33-bit compare, no wrap)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
obi_req_i  in  1  OBI A-channel request
obi_gnt_o  out  1  OBI A-channel grant (combinational)
obi_addr_i  in  32  fetch address
obi_rvalid_o  out  1  OBI R-channel valid (registered)
obi_rdata_o  out  32  fetch data (registered)
obi_err_o  out  1  bus error (registered)
mem_req_o  out  1  backing memory read request
mem_gnt_i  in  1  backing memory accepts request
mem_addr_o  out  32  backing memory word address (= obi_addr_i)
mem_rvalid_i  in  1  backing memory read data valid, in order, >=1 cycle after mem grant
mem_rdata_i  in  32  backing memory read data

Behaviour:
- Reset: obi_rvalid_o=0, obi_rdata_o=0, obi_err_o=0; tag FIFO and data FIFO empty; outstanding=0. Reset mid-operation discards all outstanding transactions; late mem_rvalid_i after reset is ignored (data FIFO write blocked while tag FIFO has no mem entry awaiting data).
- Classification, combinational: bad = !legal(obi_addr_i) || obi_addr_i[1:0]!=0.
- Tag FIFO: depth DEPTH, 1 bit per granted transaction (1=local error, 0=memory).
- Data FIFO: depth DEPTH, 32 bits.
- full = (outstanding == DEPTH). outstanding increments on grant, decrements on response emit; both in one cycle leaves it unchanged.
- A channel:
  - mem_req_o = obi_req_i && !bad && !full.
  - obi_gnt_o = obi_req_i && !full && (bad || mem_gnt_i).
  - Grant pushes the tag. A bad request never asserts mem_req_o.
  - A response popping in the same cycle does NOT free a slot for that cycle's grant; full uses the registered count.
- Response stage, evaluated each cycle on the tag FIFO head:
  - Head=1: pop the tag; next cycle obi_rvalid_o=1, obi_err_o=1, obi_rdata_o=0.
  - Head=0 and data FIFO non-empty: pop both; next cycle obi_rvalid_o=1, obi_err_o=0, obi_rdata_o=data.
  - Otherwise obi_rvalid_o=0 next cycle. obi_rdata_o and obi_err_o hold their last values when rvalid=0.
- mem_rvalid_i pushes the data FIFO. Memory responses may arrive while an error entry is still at the head; they are buffered and never dropped.
- Latency:
  - Error fetch granted in cycle t gives rvalid in t+2 if the head is free.
  - mem_rvalid_i in cycle t gives rvalid in t+2 if its tag is at the head.
  - Maximum throughput is 1 response per cycle.
- Ordering: responses are emitted in grant order regardless of error/memory mix.
- Neither FIFO can overflow: data FIFO occupancy <= memory tags outstanding <= DEPTH. Pushes and pops on the same cycle are legal at any occupancy, including full.
- Pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.

Optional Feature:
- Macro CV32E40X_OBI_RESP_STALL_EN.
- When defined:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advances every cycle.
  - When lfsr[0]=1, obi_gnt_o=0 and mem_req_o=0 (random grant stall). This exercises the master's registered/stable A-channel path.
  - The response stage is unaffected.
- When undefined: no LFSR; A-channel grant as specified above.

Test Plan:
- Single legal fetch: req at addr 32'h100, mem_gnt_i=1, mem_rvalid_i one cycle later with 32'hDEADBEEF -> gnt in cycle 0; rvalid=1, rdata=32'hDEADBEEF, err=0 in cycle 3; outstanding returns to 0.
- Error fetch: req at 32'h0001_0000 (out of range) and separately at 32'h102 (misaligned) -> gnt same cycle, mem_req_o=0, rvalid=1 err=1 rdata=0 two cycles after grant.
- Ordering: back-to-back legal A (memory delays data 5 cycles, 32'h1111_1111) then error B -> A response first with 32'h1111_1111, B err=1 the next cycle; B never overtakes A.
- Full with DEPTH=2: 3 consecutive requests, memory withholding rvalid -> gnt for the first two, third held with gnt=0 and mem_req_o=0 until the first rvalid_o; granted the cycle after the response emits.
- Reset mid-flight: 2 outstanding, rst_n pulsed low -> rvalid_o=0, FIFOs empty; a late mem_rvalid_i produces no response.
- With CV32E40X_OBI_RESP_STALL_EN: req held high 64 cycles -> gnt only when lfsr[0]=0, matching the reference LFSR sequence from seed 8'hA5; all responses correct and in order.
